boot_ctrl: RTL and testbench

// - Boot/run sequencer for the SoC core. Holds the core in reset, presents its boot address, gates instruction fetch, and latches the end-of-computation (EOC) status word that the debugger polls.
// - Sits on the peripheral APB next to the debug module, so JTAG (via system-bus access) or the core itself can start, restart and stop programs.

---
 rtl/boot_ctrl_pkg.sv | 25 ++
 rtl/boot_ctrl_regs.sv | 90 +++++++++
 rtl/boot_ctrl.sv | 141 ++++++++++++++
 tb/tb_boot_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot/run sequencer.
package boot_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } boot_state_e;

    // Register byte offsets
    localparam logic [3:0] ADDR_CTRL      = 4'h0;
    localparam logic [3:0] ADDR_BOOT_ADDR = 4'h4;
    localparam logic [3:0] ADDR_STATUS    = 4'h8;
    localparam logic [3:0] ADDR_STATE     = 4'hC;

    // CTRL bit positions
    localparam int unsigned CTRL_GO_BIT     = 0;
    localparam int unsigned CTRL_SRST_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 3;

    // STATUS payload written when the watchdog expires
    localparam logic [30:0] WDT_EXIT_CODE = 31'h7FFF_FFFF;

endpackage

// File: rtl/boot_ctrl_regs.sv
// APB decode and the CTRL / BOOT_ADDR / STATUS registers of boot_ctrl.
module boot_ctrl_regs
    import boot_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0101_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [3:0]  apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    input  boot_state_e state,
    input  logic        wdt_fired,
    input  logic        status_clr,
    input  logic        wdt_set,
    output logic [31:0] core_boot_addr,
    output logic        eoc_irq,
    output logic        go_c,
    output logic        soft_rst_c,
    output logic        eoc_wr_c,
    output logic        status_eoc
);

    logic        irq_en;
    logic [31:0] boot_addr;
    logic [31:0] status;
    logic        access;
    logic        wr_ok;
    logic        status_wr;

    // Access-phase decode: misaligned addresses and writes to STATE are errors
    always_comb begin
        access      = apb_psel && apb_penable;
        apb_pslverr = access && ((apb_paddr[1:0] != 2'b00) ||
                                 (apb_pwrite && (apb_paddr == ADDR_STATE)));
        wr_ok       = access && apb_pwrite && !apb_pslverr;
        go_c        = wr_ok && (apb_paddr == ADDR_CTRL) && apb_pwdata[CTRL_GO_BIT];
        soft_rst_c  = wr_ok && (apb_paddr == ADDR_CTRL) && apb_pwdata[CTRL_SRST_BIT];
        status_wr   = wr_ok && (apb_paddr == ADDR_STATUS) && !status[31];
        eoc_wr_c    = status_wr && apb_pwdata[31];
    end

    // Register file; STATUS is write-once per run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en    <= 1'b0;
            boot_addr <= BOOT_ADDR_RST;
            status    <= '0;
        end else begin
            if (wr_ok && (apb_paddr == ADDR_CTRL)) begin
                irq_en <= apb_pwdata[CTRL_IRQ_EN_BIT];
            end
            if (wr_ok && (apb_paddr == ADDR_BOOT_ADDR)) begin
                boot_addr <= {apb_pwdata[31:2], 2'b00};
            end
            if (soft_rst_c || status_clr) begin
                status <= '0;
            end else if (wdt_set) begin
                status <= {1'b1, WDT_EXIT_CODE};
            end else if (status_wr) begin
                status <= apb_pwdata;
            end
        end
    end

    // Combinational read mux straight from the registers
    always_comb begin
        apb_prdata = '0;
        if (apb_psel && !apb_pwrite && (apb_paddr[1:0] == 2'b00)) begin
            case (apb_paddr)
                ADDR_CTRL:      apb_prdata[CTRL_IRQ_EN_BIT] = irq_en;
                ADDR_BOOT_ADDR: apb_prdata = boot_addr;
                ADDR_STATUS:    apb_prdata = status;
                ADDR_STATE:     apb_prdata = {23'd0, wdt_fired, 6'd0, state};
                default:        apb_prdata = '0;
            endcase
        end
    end

    assign apb_pready     = 1'b1;
    assign core_boot_addr = boot_addr;
    assign status_eoc     = status[31];
    assign eoc_irq        = status[31] && irq_en;

endmodule

// File: rtl/boot_ctrl.sv
// Boot/run sequencer: core reset hold, fetch gating, EOC latch.
// Optional RUN-state watchdog enabled by defining BOOT_CTRL_WDT_EN.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0101_0080,
    parameter int unsigned RST_HOLD_CYC  = 16,
    parameter bit          AUTO_BOOT     = 1'b0,
    parameter logic [31:0] WDT_CYC       = 32'd8_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [3:0]  apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic        core_rst_n,
    output logic        core_fetch_en,
    output logic [31:0] core_boot_addr,
    output logic        eoc_irq
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

    boot_state_e       state;
    boot_state_e       state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              rst_n_next;
    logic              fetch_next;
    logic              go_c;
    logic              soft_rst_c;
    logic              eoc_wr_c;
    logic              status_eoc;
    logic              status_clr_c;
    logic              wdt_fire_c;
    logic              wdt_fired;

    boot_ctrl_regs #(
        .BOOT_ADDR_RST (BOOT_ADDR_RST)
    ) u_regs (
        .clk            (clk),
        .reset          (reset),
        .apb_psel       (apb_psel),
        .apb_penable    (apb_penable),
        .apb_pwrite     (apb_pwrite),
        .apb_paddr      (apb_paddr),
        .apb_pwdata     (apb_pwdata),
        .apb_prdata     (apb_prdata),
        .apb_pready     (apb_pready),
        .apb_pslverr    (apb_pslverr),
        .state          (state),
        .wdt_fired      (wdt_fired),
        .status_clr     (status_clr_c),
        .wdt_set        (wdt_fire_c),
        .core_boot_addr (core_boot_addr),
        .eoc_irq        (eoc_irq),
        .go_c           (go_c),
        .soft_rst_c     (soft_rst_c),
        .eoc_wr_c       (eoc_wr_c),
        .status_eoc     (status_eoc)
    );

    assign hold_done    = (hold_cnt == HOLD_W'(RST_HOLD_CYC - 1));
    assign status_clr_c = go_c && (state == DONE) && !soft_rst_c;

`ifdef BOOT_CTRL_WDT_EN
    logic [31:0] wdt_cnt;

    // A same-cycle software EOC (or one already latched) pre-empts the watchdog
    assign wdt_fire_c = (state == RUN) && (wdt_cnt == (WDT_CYC - 32'd1)) &&
                        !status_eoc && !eoc_wr_c && !soft_rst_c;

    // Watchdog count of RUN cycles; zero on every RUN entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_cnt   <= '0;
            wdt_fired <= 1'b0;
        end else begin
            wdt_cnt <= ((state == RUN) && (state_next == RUN)) ? wdt_cnt + 32'd1 : 32'd0;
            if (soft_rst_c) begin
                wdt_fired <= 1'b0;
            end else if (wdt_fire_c) begin
                wdt_fired <= 1'b1;
            end
        end
    end
`else
    logic wdt_cyc_unused;

    assign wdt_cyc_unused = ^{WDT_CYC, eoc_wr_c};
    assign wdt_fire_c     = 1'b0;
    assign wdt_fired      = 1'b0;
`endif

    // Hold counter: runs only while staying in HOLD, zero otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if ((state == HOLD) && !soft_rst_c && !hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // State and registered core controls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= HOLD;
            core_rst_n    <= 1'b0;
            core_fetch_en <= 1'b0;
        end else begin
            state         <= state_next;
            core_rst_n    <= rst_n_next;
            core_fetch_en <= fetch_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        case (state)
            HOLD: if (hold_done)              state_next = IDLE;
            IDLE: if (go_c || AUTO_BOOT)      state_next = RUN;
            RUN:  if (status_eoc || wdt_fire_c) state_next = DONE;
            DONE: if (go_c)                   state_next = RUN;
            default:                          state_next = HOLD;
        endcase
        if (soft_rst_c) begin
            state_next = HOLD;
        end
        rst_n_next = (state_next != HOLD);
        fetch_next = (state_next == RUN);
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: cycle model plus directed APB sequences.
module tb_boot_ctrl;

    localparam int          HOLD_N   = 16;
    localparam logic [31:0] BOOT_RST = 32'h0101_0080;
    localparam int          WDT_LIM  = 100;
`ifdef BOOT_CTRL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = 4'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        core_rst_n;
    logic        fetch_en;
    logic [31:0] boot_addr;
    logic        eoc_irq;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    boot_ctrl #(
        .BOOT_ADDR_RST (BOOT_RST),
        .RST_HOLD_CYC  (HOLD_N),
        .AUTO_BOOT     (1'b0),
        .WDT_CYC       (32'(WDT_LIM))
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .apb_psel       (psel),
        .apb_penable    (penable),
        .apb_pwrite     (pwrite),
        .apb_paddr      (paddr),
        .apb_pwdata     (pwdata),
        .apb_prdata     (prdata),
        .apb_pready     (pready),
        .apb_pslverr    (pslverr),
        .core_rst_n     (core_rst_n),
        .core_fetch_en  (fetch_en),
        .core_boot_addr (boot_addr),
        .eoc_irq        (eoc_irq)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // m_state: 0 hold, 1 idle, 2 run, 3 done
    int          m_state, n_state;
    int          m_hold, n_hold;
    int          m_run, n_run;
    logic [31:0] m_status, n_status;
    logic [31:0] m_boot, n_boot;
    logic        m_irq_en, n_irq_en;
    logic        m_fired, n_fired;

    logic acc, bad, okw, go, srst, st_wr;

    always_comb begin
        acc   = psel && penable;
        bad   = acc && ((paddr % 4) != 0 || (pwrite && paddr == 4'hC));
        okw   = acc && pwrite && !bad;
        go    = okw && paddr == 4'h0 && pwdata[0];
        srst  = okw && paddr == 4'h0 && pwdata[1];
        st_wr = okw && paddr == 4'h8 && !m_status[31];

        n_state  = m_state;
        n_hold   = m_hold;
        n_run    = m_run;
        n_boot   = m_boot;
        n_irq_en = m_irq_en;
        n_fired  = m_fired;
        n_status = st_wr ? pwdata : m_status;
        if (okw && paddr == 4'h4) n_boot = pwdata & 32'hFFFF_FFFC;
        if (okw && paddr == 4'h0) n_irq_en = pwdata[3];

        if (srst) begin
            n_state  = 0;
            n_hold   = 0;
            n_status = 32'h0;
            n_fired  = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    n_hold = m_hold + 1;
                    if (n_hold == HOLD_N) begin
                        n_state = 1;
                        n_hold  = 0;
                    end
                end
                1: if (go) begin
                    n_state = 2;
                    n_run   = 0;
                end
                2: begin
                    if (m_status[31]) begin
                        n_state = 3;
                    end else begin
                        n_run = m_run + 1;
                        if (WDT_ON && n_run == WDT_LIM && !(st_wr && pwdata[31])) begin
                            n_status = 32'hFFFF_FFFF;
                            n_fired  = 1'b1;
                            n_state  = 3;
                        end
                    end
                end
                default: if (go) begin
                    n_status = 32'h0;
                    n_state  = 2;
                    n_run    = 0;
                end
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state  <= 0;
            m_hold   <= 0;
            m_run    <= 0;
            m_status <= 32'h0;
            m_boot   <= BOOT_RST;
            m_irq_en <= 1'b0;
            m_fired  <= 1'b0;
        end else begin
            m_state  <= n_state;
            m_hold   <= n_hold;
            m_run    <= n_run;
            m_status <= n_status;
            m_boot   <= n_boot;
            m_irq_en <= n_irq_en;
            m_fired  <= n_fired;
        end
    end

    // Per-cycle comparison of the core-facing outputs against the model
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("cyc_core_rst_n", 32'(core_rst_n), 32'(m_state != 0));
            check("cyc_fetch_en", 32'(fetch_en), 32'(m_state == 2));
            check("cyc_boot_addr", boot_addr, m_boot);
            check("cyc_eoc_irq", 32'(eoc_irq), 32'(m_status[31] && m_irq_en));
        end
    end

    // ---------------- APB helpers ----------------
    task automatic apb(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd  = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [3:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, a, d, rd, err);
        check({nm, "_slverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rd(input string nm, input logic [3:0] a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] v;
        logic        err;
        apb(1'b0, a, 32'h0, v, err);
        check(nm, v, exp);
        check({nm, "_slverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic wait_rst_high(input string nm);
        int k = 0;
        while (core_rst_n !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(core_rst_n), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lows;

        repeat (3) @(negedge clk);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_fetch_en", 32'(fetch_en), 32'd0);
        check("rst_boot_addr", boot_addr, BOOT_RST);
        check("rst_eoc_irq", 32'(eoc_irq), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("pready", 32'(pready), 32'd1);

        // Release on a negedge and count cycles with the core still in reset
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        lows   = 0;
        while (core_rst_n === 1'b0 && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        check("hold_cycles", 32'(lows), 32'd16);
        rd("state_idle", 4'hC, 32'h1, 1'b0);
        rd("boot_addr_rst", 4'h4, 32'h0101_0080, 1'b0);

        // Boot address write, then go
        wr("wr_boot", 4'h4, 32'h0101_0103, 1'b0);
        rd("boot_addr_aligned", 4'h4, 32'h0101_0100, 1'b0);
        check("fetch_before_go", 32'(fetch_en), 32'd0);
        wr("go", 4'h0, 32'h1, 1'b0);
        check("fetch_after_go", 32'(fetch_en), 32'd1);
        rd("state_run", 4'hC, 32'h2, 1'b0);

        // EOC: fetch drops two cycles after the write
        wr("eoc", 4'h8, 32'h8000_0000, 1'b0);
        check("fetch_eoc_n1", 32'(fetch_en), 32'd1);
        @(negedge clk);
        check("fetch_eoc_n2", 32'(fetch_en), 32'd0);
        rd("state_done", 4'hC, 32'h3, 1'b0);
        wr("eoc_overwrite", 4'h8, 32'h8000_0005, 1'b0);
        rd("status_kept", 4'h8, 32'h8000_0000, 1'b0);
        wr("irq_en", 4'h0, 32'h8, 1'b0);
        check("eoc_irq_on", 32'(eoc_irq), 32'd1);
        rd("ctrl_rd", 4'h0, 32'h8, 1'b0);

        // Restart from DONE clears STATUS
        wr("go_done", 4'h0, 32'h9, 1'b0);
        rd("status_cleared", 4'h8, 32'h0, 1'b0);
        check("eoc_irq_off", 32'(eoc_irq), 32'd0);
        rd("state_rerun", 4'hC, 32'h2, 1'b0);
        wr("eoc2", 4'h8, 32'h8000_0000, 1'b0);
        @(negedge clk);
        rd("state_done2", 4'hC, 32'h3, 1'b0);

        // go + soft_rst together: soft_rst wins
        wr("go_srst", 4'h0, 32'h3, 1'b0);
        check("srst_core_rst_n", 32'(core_rst_n), 32'd0);
        rd("state_hold", 4'hC, 32'h0, 1'b0);
        rd("status_srst", 4'h8, 32'h0, 1'b0);
        wait_rst_high("hold_exit");
        rd("state_idle2", 4'hC, 32'h1, 1'b0);

        // Error accesses change nothing
        wr("wr_state_reg", 4'hC, 32'h3, 1'b1);
        rd("state_after_err", 4'hC, 32'h1, 1'b0);
        wr("wr_misaligned", 4'h6, 32'hFFFF_FFFF, 1'b1);
        rd("rd_misaligned", 4'h6, 32'h0, 1'b1);
        wr("go_misaligned", 4'h1, 32'h1, 1'b1);
        rd("boot_after_err", 4'h4, 32'h0101_0100, 1'b0);
        rd("status_after_err", 4'h8, 32'h0, 1'b0);
        rd("state_after_err2", 4'hC, 32'h1, 1'b0);

        // Long run with no EOC
        wr("go_long", 4'h0, 32'h1, 1'b0);
        repeat (WDT_LIM + 10) @(negedge clk);
`ifdef BOOT_CTRL_WDT_EN
        check("wdt_fetch", 32'(fetch_en), 32'd0);
        rd("wdt_status", 4'h8, 32'hFFFF_FFFF, 1'b0);
        rd("wdt_state", 4'hC, 32'h103, 1'b0);
        wr("go_after_wdt", 4'h0, 32'h1, 1'b0);
        rd("status_after_wdt_go", 4'h8, 32'h0, 1'b0);
        rd("state_after_wdt_go", 4'hC, 32'h102, 1'b0);
`else
        check("nowdt_fetch", 32'(fetch_en), 32'd1);
        rd("nowdt_state", 4'hC, 32'h2, 1'b0);
        rd("nowdt_status", 4'h8, 32'h0, 1'b0);
`endif
        wr("srst_final", 4'h0, 32'h2, 1'b0);
        rd("state_final", 4'hC, 32'h0, 1'b0);
        wait_rst_high("hold_exit2");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
